// File: rtl/word16_fifo_pkg.sv
// Shared definitions for the 16-bit output FIFO of the 8->16 width converter.
//   DW_DEF / DEPTH_DEF : default word width and entry count
//   ptr_w(depth)       : pointer width including the wrap bit
//   word_t             : default-width data word
package word16_fifo_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 4;

  // One extra MSB beyond the address bits distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [DW_DEF-1:0] word_t;

endpackage

// File: rtl/word16_fifo_mem.sv
// DEPTH x DW word storage for word16_out_fifo.
// One synchronous write port, one asynchronous read port; contents are not reset.
// Ports:
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module word16_fifo_mem
  import word16_fifo_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/word16_out_fifo.sv
// Downstream stage of the 8->16 width converter. Captures every word from the
// converter's valid-only output, buffers up to DEPTH words and presents them
// show-ahead over a valid/ready handshake. The producer cannot be stalled, so a
// word arriving while full (and no same-cycle pop) is dropped and recorded in a
// sticky overflow flag.
// Optional feature macro: WORD16_OUT_FIFO_LEVEL_EN adds the occupancy port 'level'.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   valid_in  : word present on data_in
//   data_in   : input word
//   valid_out : head word available
//   data_out  : head word, 0 when empty
//   ready_in  : consumer accepts data_out
//   overflow  : sticky, at least one word dropped
//   ovf_clr   : synchronous clear of overflow (a same-cycle drop wins)
//   level     : occupancy 0..DEPTH (only with WORD16_OUT_FIFO_LEVEL_EN)
module word16_out_fifo
  import word16_fifo_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF   // power of 2, >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [DW-1:0]          data_in,
  output logic                   valid_out,
  output logic [DW-1:0]          data_out,
  input  logic                   ready_in,
  output logic                   overflow,
`ifdef WORD16_OUT_FIFO_LEVEL_EN
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] level
`else
  input  logic                   ovf_clr
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, push, pop, drop;
  logic [DW-1:0] rdata;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign pop  = valid_out && ready_in;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = valid_in && (!full || pop);
  assign drop = valid_in && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  word16_fifo_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  // Outputs derive from the pointers only, so reset clears them asynchronously.
  assign valid_out = !empty;
  assign data_out  = empty ? '0 : rdata;

`ifdef WORD16_OUT_FIFO_LEVEL_EN
  assign level = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_word16_out_fifo.sv
module tb_word16_out_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, ready_in, ovf_clr;
  logic [DW-1:0] data_in;
  logic          valid_out, overflow;
  logic [DW-1:0] data_out;
`ifdef WORD16_OUT_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] sb_q [$];
  logic          m_ovf = 1'b0;

  always #5 clk = ~clk;

  word16_out_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in),
    .overflow  (overflow),
`ifdef WORD16_OUT_FIFO_LEVEL_EN
    .ovf_clr   (ovf_clr),
    .level     (level)
`else
    .ovf_clr   (ovf_clr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard/model: evaluated at negedge, where inputs and outputs are stable.
  always @(negedge clk) begin
    bit            pop, push, full;
    logic [DW-1:0] exp_d;
    if (rst) begin
      sb_q.delete();
      m_ovf = 1'b0;
    end else begin
      chk("valid_out", 32'(valid_out), 32'(sb_q.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef WORD16_OUT_FIFO_LEVEL_EN
      chk("level", 32'(level), 32'(sb_q.size()));
`endif
      if (sb_q.size() == 0) chk("data_empty", 32'(data_out), 32'h0);
      full = (sb_q.size() == DEPTH);
      pop  = (sb_q.size() != 0) && ready_in;
      push = valid_in && (!full || pop);
      if (pop) begin
        exp_d = sb_q.pop_front();
        chk("drain_data", 32'(data_out), 32'(exp_d));
      end
      if (push) sb_q.push_back(data_in);
      if (valid_in && full && !pop) m_ovf = 1'b1;
      else if (ovf_clr)             m_ovf = 1'b0;
    end
  end

  task automatic drive(input logic vi, input logic [DW-1:0] d, input logic rdy, input logic clr);
    valid_in = vi; data_in = d; ready_in = rdy; ovf_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    idle(1);

    // 1: single word, held until popped
    drive(1'b1, 16'hA55A, 1'b0, 1'b0);
    chk("t1_valid", 32'(valid_out), 32'h1);
    chk("t1_data", 32'(data_out), 32'hA55A);
    idle(2);
    chk("t1_hold", 32'(data_out), 32'hA55A);
    drain(1);
    chk("t1_after_pop_v", 32'(valid_out), 32'h0);
    chk("t1_after_pop_d", 32'(data_out), 32'h0);

    // 2: fill, drop fifth word, drain in order
    for (int i = 1; i <= 5; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    chk("t2_ovf", 32'(overflow), 32'h1);
    chk("t2_head", 32'(data_out), 32'h0001);
    drain(4);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t2_clr", 32'(overflow), 32'h0);

    // 3: full with simultaneous push and pop
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(16'h0011 + i), 1'b0, 1'b0);
    drive(1'b1, 16'h00AA, 1'b1, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'h0);
    chk("t3_head", 32'(data_out), 32'h0012);
    drain(4);
    chk("t3_empty", 32'(valid_out), 32'h0);

    // 4: streaming across pointer wrap
    for (int i = 0; i < 10; i++) drive(1'b1, DW'(16'h1000 + i), 1'b1, 1'b0);
    chk("t4_last", 32'(data_out), 32'h1009);
    drain(1);
    chk("t4_ovf", 32'(overflow), 32'h0);

    // 5: clear collides with a drop; set wins
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(16'h2000 + i), 1'b0, 1'b0);
    drive(1'b1, 16'h0055, 1'b0, 1'b0);
    drive(1'b1, 16'h0066, 1'b0, 1'b1);
    chk("t5_set_wins", 32'(overflow), 32'h1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t5_clr", 32'(overflow), 32'h0);
    drain(4);

    // 6: async reset with 3 words and overflow set
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(16'h3000 + i), 1'b0, 1'b0);
    drive(1'b1, 16'h3333, 1'b0, 1'b0);
    drain(1);
    chk("t6_pre_ovf", 32'(overflow), 32'h1);
`ifdef WORD16_OUT_FIFO_LEVEL_EN
    chk("t6_pre_level", 32'(level), 32'h3);
`endif
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(valid_out), 32'h0);
    chk("t6_rst_ovf", 32'(overflow), 32'h0);
`ifdef WORD16_OUT_FIFO_LEVEL_EN
    chk("t6_rst_level", 32'(level), 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    chk("t6_post_valid", 32'(valid_out), 32'h0);
    drive(1'b1, 16'h0077, 1'b0, 1'b0);
    chk("t6_new_data", 32'(data_out), 32'h0077);
    drain(1);
    idle(1);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
